sram_arbiter: RTL and testbench

//  Shares the single-port SRAM between two bus masters: m0 (CPU control-unit fetch/load/store path) and
//  m1 (program loader / debug port). Each master uses a req/ack handshake; the arbiter picks one

---
 rtl/sram_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM: one access per IDLE->ACCESS->DONE pass.
// All outputs are registered; round-robin or fixed-priority tie-break chosen by RR_EN.
module sram_arbiter #(
   parameter int AW    = 8,
   parameter int DW    = 16,
   parameter bit RR_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [0:AW-1] m0_addr,
   input  logic [0:DW-1] m0_wdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [0:AW-1] m1_addr,
   input  logic [0:DW-1] m1_wdata,
   output logic          m1_ack,
   output logic [0:DW-1] rdata,
   output logic          gnt,
   output logic          busy,
   output logic          sram_en,
   output logic          write_en,
   output logic [0:AW-1] sram_addr,
   output logic [0:DW-1] sram_wdata,
   input  logic [0:DW-1] sram_rdata
);

   // state  | meaning
   // IDLE   | sample requests, pick a winner, start the strobe
   // ACCESS | SRAM strobe active for exactly one cycle, capture read data
   // DONE   | ack visible to the winner, requests ignored
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state, state_n;
   logic          last_grant, last_grant_n;
   logic          win;
   logic          m0_ack_n, m1_ack_n, gnt_n, busy_n, sram_en_n, write_en_n;
   logic [0:AW-1] sram_addr_n;
   logic [0:DW-1] sram_wdata_n, rdata_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         gnt        <= 1'b0;
         busy       <= 1'b0;
         sram_en    <= 1'b1;
         write_en   <= 1'b1;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rdata      <= '0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         m0_ack     <= m0_ack_n;
         m1_ack     <= m1_ack_n;
         gnt        <= gnt_n;
         busy       <= busy_n;
         sram_en    <= sram_en_n;
         write_en   <= write_en_n;
         sram_addr  <= sram_addr_n;
         sram_wdata <= sram_wdata_n;
         rdata      <= rdata_n;
      end
   end

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      m0_ack_n     = m0_ack;
      m1_ack_n     = m1_ack;
      gnt_n        = gnt;
      busy_n       = busy;
      sram_en_n    = sram_en;
      write_en_n   = write_en;
      sram_addr_n  = sram_addr;
      sram_wdata_n = sram_wdata;
      rdata_n      = rdata;
      win          = 1'b0;

      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               // on a tie the master that did not win last time goes next
               if (m0_req && m1_req) win = RR_EN ? ~last_grant : 1'b0;
               else                  win = m1_req;
               sram_addr_n  = win ? m1_addr  : m0_addr;
               sram_wdata_n = win ? m1_wdata : m0_wdata;
               write_en_n   = win ? ~m1_we   : ~m0_we;
               sram_en_n    = 1'b0;
               gnt_n        = win;
               last_grant_n = win;
               busy_n       = 1'b1;
               state_n      = ACCESS;
            end
         end
         ACCESS: begin
            if (write_en) rdata_n = sram_rdata;
            if (gnt) m1_ack_n = 1'b1;
            else     m0_ack_n = 1'b1;
            sram_en_n  = 1'b1;
            write_en_n = 1'b1;
            state_n    = DONE;
         end
         DONE: begin
            m0_ack_n = 1'b0;
            m1_ack_n = 1'b0;
            busy_n   = 1'b0;
            state_n  = IDLE;
         end
         default: begin
            m0_ack_n   = 1'b0;
            m1_ack_n   = 1'b0;
            busy_n     = 1'b0;
            sram_en_n  = 1'b1;
            write_en_n = 1'b1;
            state_n    = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: SRAM model, expected-access scoreboard, latency/priority/reset checks.
module tb_sram_arbiter;

   typedef struct {
      logic        m;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [0:7]  m0_addr = '0, m1_addr = '0;
   logic [0:15] m0_wdata = '0, m1_wdata = '0;
   logic        m0_ack, m1_ack, gnt, busy, sram_en, write_en;
   logic [0:15] rdata, sram_wdata, sram_rdata;
   logic [0:7]  sram_addr;

   logic        f_m0_req = 1'b0, f_m1_req = 1'b0;
   logic        f_m0_ack, f_m1_ack, f_gnt, f_busy, f_sram_en, f_write_en;
   logic [0:15] f_rdata, f_sram_wdata, f_sram_rdata;
   logic [0:7]  f_sram_addr;

   logic [15:0] mem [0:255];
   logic        init_mem = 1'b1;
   exp_t        sb[$];
   int          acc_times[$];
   int          nerr = 0, nchk = 0, cyc = 0, wr_cycles = 0;

   sram_arbiter #(.AW(8), .DW(16), .RR_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
      .rdata(rdata), .gnt(gnt), .busy(busy), .sram_en(sram_en), .write_en(write_en),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   sram_arbiter #(.AW(8), .DW(16), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .m0_req(f_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(f_m0_ack),
      .m1_req(f_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(f_m1_ack),
      .rdata(f_rdata), .gnt(f_gnt), .busy(f_busy), .sram_en(f_sram_en), .write_en(f_write_en),
      .sram_addr(f_sram_addr), .sram_wdata(f_sram_wdata), .sram_rdata(f_sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (init_mem) mem[8'h12] <= 16'hBEEF;
      else if (!sram_en && !write_en) mem[sram_addr] <= sram_wdata;
   end

   assign sram_rdata   = mem[sram_addr];
   assign f_sram_rdata = mem[f_sram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic m, input logic we, input logic [7:0] a, input logic [15:0] d);
      exp_t e;
      e.m = m; e.we = we; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input bit which, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (which ? m1_ack : m0_ack) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_ack_timeout"}, {31'd0, seen}, 32'd1);
   endtask

   // scoreboard: peek on the strobe cycle, pop on the ack
   always @(negedge clk) begin
      if (!reset) begin
         check("we_low_without_en", {31'd0, (!write_en && sram_en)}, 32'd0);
         if (!sram_en) begin
            acc_times.push_back(cyc);
            if (!write_en) wr_cycles++;
            if (sb.size() == 0) check("unexpected_access", 32'd1, 32'd0);
            else begin
               check("acc_addr", {24'd0, sram_addr}, {24'd0, sb[0].addr});
               check("acc_we", {31'd0, ~write_en}, {31'd0, sb[0].we});
               check("acc_gnt", {31'd0, gnt}, {31'd0, sb[0].m});
               if (sb[0].we) check("acc_wdata", {16'd0, sram_wdata}, {16'd0, sb[0].data});
            end
         end
         if (m0_ack || m1_ack) begin
            check("ack_onehot", {31'd0, m0_ack && m1_ack}, 32'd0);
            if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
               if (!e.we) check("ack_rdata", {16'd0, rdata}, {16'd0, e.data});
            end
         end
      end
   end

   initial begin
      int n0, n1, acks;
      // 1: reset values
      step(); init_mem = 1'b0;
      step();
      check("rst_sram_en", {31'd0, sram_en}, 32'd1);
      check("rst_write_en", {31'd0, write_en}, 32'd1);
      check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_gnt", {31'd0, gnt}, 32'd0);
      reset = 1'b0;
      step();

      // 2: m0 read, latency and strobe shape
      push(1'b0, 1'b0, 8'h12, 16'hBEEF);
      m0_we = 1'b0; m0_addr = 8'h12; m0_req = 1'b1;
      step();
      check("t2_en_low", {31'd0, sram_en}, 32'd0);
      check("t2_addr", {24'd0, sram_addr}, 32'h12);
      check("t2_we_high", {31'd0, write_en}, 32'd1);
      check("t2_busy", {31'd0, busy}, 32'd1);
      check("t2_no_early_ack", {31'd0, m0_ack}, 32'd0);
      step();
      check("t2_m0_ack", {31'd0, m0_ack}, 32'd1);
      check("t2_m1_ack", {31'd0, m1_ack}, 32'd0);
      check("t2_rdata", {16'd0, rdata}, 32'hBEEF);
      check("t2_en_released", {31'd0, sram_en}, 32'd1);
      m0_req = 1'b0;
      step();
      check("t2_ack_one_cycle", {31'd0, m0_ack}, 32'd0);
      check("t2_idle", {31'd0, busy}, 32'd0);
      step();

      // 3: m1 write then m0 read back
      wr_cycles = 0;
      push(1'b1, 1'b1, 8'h40, 16'hA5A5);
      m1_we = 1'b1; m1_addr = 8'h40; m1_wdata = 16'hA5A5; m1_req = 1'b1;
      wait_ack(1'b1, "t3_wr");
      check("t3_gnt", {31'd0, gnt}, 32'd1);
      check("t3_wr_cycles", wr_cycles, 32'd1);
      check("t3_rdata_kept", {16'd0, rdata}, 32'hBEEF);
      m1_req = 1'b0;
      step();
      push(1'b0, 1'b0, 8'h40, 16'hA5A5);
      m0_we = 1'b0; m0_addr = 8'h40; m0_req = 1'b1;
      wait_ack(1'b0, "t3_rd");
      check("t3_rd_rdata", {16'd0, rdata}, 32'hA5A5);
      check("t3_rd_gnt", {31'd0, gnt}, 32'd0);
      m0_req = 1'b0;
      step();

      // 4: round-robin with both held high (reset restores m0-first)
      reset = 1'b1; step(); reset = 1'b0;
      acc_times.delete();
      push(1'b0, 1'b0, 8'h12, 16'hBEEF);
      push(1'b1, 1'b0, 8'h40, 16'hA5A5);
      push(1'b0, 1'b0, 8'h12, 16'hBEEF);
      push(1'b1, 1'b0, 8'h40, 16'hA5A5);
      m0_we = 1'b0; m0_addr = 8'h12; m1_we = 1'b0; m1_addr = 8'h40;
      m0_req = 1'b1; m1_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         step();
         if (m0_ack || m1_ack) acks++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      check("t4_acks", acks, 32'd4);
      if (acc_times.size() < 4) check("t4_accesses", acc_times.size(), 32'd4);
      else for (int i = 0; i < 3; i++)
         check("t4_spacing", acc_times[i+1] - acc_times[i], 32'd3);
      step(); step();

      // 5: fixed priority instance
      f_m0_req = 1'b1; f_m1_req = 1'b1;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 30 && n0 < 3; i++) begin
         step();
         if (f_m0_ack) n0++;
         if (f_m1_ack) n1++;
      end
      check("t5_m0_acks", n0, 32'd3);
      check("t5_m1_starved", n1, 32'd0);
      check("t5_m0_rdata", {16'd0, f_rdata}, 32'hBEEF);
      f_m0_req = 1'b0;
      step(); step();
      check("t5_m1_gnt", {31'd0, f_gnt}, 32'd1);
      check("t5_m1_strobe", {31'd0, f_sram_en}, 32'd0);
      step();
      check("t5_m1_ack", {31'd0, f_m1_ack}, 32'd1);
      check("t5_m1_rdata", {16'd0, f_rdata}, 32'hA5A5);
      f_m1_req = 1'b0;
      step(); step();

      // 6: reset during ACCESS of an m1 write, then retry
      push(1'b1, 1'b1, 8'h50, 16'h1234);
      m1_we = 1'b1; m1_addr = 8'h50; m1_wdata = 16'h1234; m1_req = 1'b1;
      step();
      check("t6_in_write", {30'd0, sram_en, write_en}, 32'd0);
      reset = 1'b1;
      step();
      check("t6_rst_en", {31'd0, sram_en}, 32'd1);
      check("t6_rst_we", {31'd0, write_en}, 32'd1);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_no_ack", {31'd0, m1_ack}, 32'd0);
      reset = 1'b0;
      wait_ack(1'b1, "t6_retry");
      check("t6_retry_gnt", {31'd0, gnt}, 32'd1);
      m1_req = 1'b0;
      step();
      push(1'b0, 1'b0, 8'h50, 16'h1234);
      m0_we = 1'b0; m0_addr = 8'h50; m0_req = 1'b1;
      wait_ack(1'b0, "t6_readback");
      m0_req = 1'b0;
      step(); step();

      check("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
